// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, reset PC, NOP encoding
// and the fetch queue entry layout.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam logic [31:0] RESET_PC = 32'h01000000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x fetch_entry_t registers with one write port and
// one asynchronous read port. Contents are not reset; occupancy masks them.
module fetch_queue_mem
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t  o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: registered valid/ready FIFO between fetch and decode
// with redirect flush. in_ready depends only on registered occupancy.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_insn,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_insn,
    output logic                     out_misaligned,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_enq;
    logic          w_deq;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_enq = in_valid && in_ready && !flush;
    assign w_deq = out_valid && out_ready && !flush;

    assign w_wdata.pc         = in_pc;
    assign w_wdata.insn       = in_insn;
    assign w_wdata.misaligned = |in_pc[1:0];

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        out_pc         = '0;
        out_insn       = NOP_INSN;
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_pc         = w_head.pc;
            out_insn       = w_head.insn;
            out_misaligned = w_head.misaligned;
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue that consumes the `{pc, instruction}` stream produced by the PC counter and instruction memory. It presents that stream to decode through a registered valid/ready FIFO. It decouples fetch from decode stalls, drives back-pressure (`in_ready`) to hold the PC, and discards all in-flight fetches when a PC redirect (branch/jump, PC_sel = 1) occurs.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; power of two, ≥ 2.
- `XLEN`, 32: PC and instruction width.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  fetch stage presents a valid `{in_pc, in_insn}`.
- `in_pc`  in  XLEN  PC of fetched instruction.
- `in_insn`  in  XLEN  fetched instruction word.
- `in_ready`  out  1  queue can accept an entry; low stalls the PC counter.
- `flush`  in  1  redirect: discard all entries and any same-cycle enqueue.
- `out_valid`  out  1  head entry valid for decode.
- `out_pc`  out  XLEN  head PC.
- `out_insn`  out  XLEN  head instruction.
- `out_misaligned`  out  1  head PC has `pc[1:0] != 0`.
- `out_ready`  in  1  decode consumes head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of `{pc, insn, misaligned}`, read pointer `rd_ptr`, write pointer `wr_ptr`, occupancy `count`.
- Enqueue: `enq = in_valid && in_ready && !flush`.
  - Writes the entry at `wr_ptr` and increments `wr_ptr` modulo DEPTH.
  - `misaligned` is captured as `|in_pc[1:0]`.
- Dequeue: `deq = out_valid && out_ready && !flush`. Increments `rd_ptr` modulo DEPTH.
- `count` update:
  - +1 on enq only.
  - −1 on deq only.
  - Unchanged on both or neither.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`. When full, a same-cycle dequeue does not open a slot until the next cycle.
- `out_valid = (count != 0)`.
- Head outputs:
  - When `out_valid`, `out_pc`, `out_insn` and `out_misaligned` come from the entry at `rd_ptr`.
  - When empty, `out_pc = 0`, `out_insn = NOP (32'h00000013)` and `out_misaligned = 0`.
- Flush has priority over enqueue and dequeue. At the next edge: `count = 0`, `rd_ptr = wr_ptr = 0`. The same-cycle `in_*` entry is dropped.
- Reset has priority over flush and yields the same state. Storage contents need not be cleared; they are masked by `count = 0`.
- No internal FSM beyond the pointer/occupancy state. Implicit states are EMPTY (count = 0), PARTIAL and FULL (count = DEPTH).

## Timing
- Enqueue-to-output latency: 1 cycle. An entry written at edge N is visible on `out_*` with `out_valid = 1` after edge N.
- No same-cycle pass-through when empty.
- `in_ready` reflects occupancy after the previous edge.
- Reset values:
  - `in_ready = 1`, `out_valid = 0`, `count = 0`.
  - `out_pc = 0`, `out_insn = 32'h00000013`, `out_misaligned = 0`.
- Boundary conditions:
  - Full with `out_ready = 1`: dequeue only; `count` becomes DEPTH−1; `in_ready = 1` next cycle.
  - Empty with `out_ready = 1`: no dequeue, and `count` does not underflow.
  - Pointers wrap at DEPTH−1 → 0.
  - FIFO order is preserved across the wrap.
  - Flush while `in_valid = 1`: the entry is lost and the PC counter is expected to present the redirect target on the following cycle.
  - Flush while full: `in_ready = 1` on the next cycle.
  - Reset mid-stream: all entries discarded; outputs return to reset values after the edge.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`.
  - `NOP_INSN = 32'h00000013`.
  - `RESET_PC = 32'h01000000`.
  - Typedef `fetch_entry_t {pc, insn, misaligned}`.
- One sub-module is natural: `fetch_queue_mem`, a DEPTH × `fetch_entry_t` register array with one write port and one asynchronous read port.
- Pointer, occupancy and flush logic stay in `fetch_queue`.

## Test plan
- Reset, then idle → `in_ready = 1`, `out_valid = 0`, `out_insn = 32'h00000013`, `count = 0`.
- Enqueue PCs 0x01000000, 0x01000004 with `out_ready = 0` → `count = 2`, `in_ready = 0`; a third `in_valid` is ignored. Raise `out_ready` → decode sees 0x01000000 then 0x01000004 in order.
- Streaming with `out_ready = 1`, `in_valid = 1` for 8 cycles at PC +4 each → every PC appears once, in order, 1 cycle after enqueue; `count` stays at 1 and pointers wrap correctly.
- Full queue, `flush = 1` with `in_valid = 1`, `in_pc = 0x01000040` → next cycle `count = 0`, `out_valid = 0`, `in_ready = 1`; the following enqueue of 0x01000080 is the next entry decode sees.
- Enqueue `in_pc = 0x01000002` → head shows `out_misaligned = 1`; the next aligned entry shows 0.
- Reset asserted with 2 entries queued and `in_valid` high → after the edge, reset values; no stale entry appears on `out_*`.
